// File: rtl/mems_spi_tx.sv
// SPI frame transmitter for the MEMS driver DAC: one WORD_W-bit frame per start pulse,
// MSB first, sclk idling high, DAC sampling on the falling edge, sync_n framing each word.
module mems_spi_tx #(
    parameter int unsigned WORD_W   = 24,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SYNC_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              sync_n
);

    localparam int unsigned BitW = $clog2(WORD_W) + 1;
    localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
    localparam int unsigned GapW = $clog2(SYNC_GAP) + 1;

    localparam logic [BitW-1:0] LastBit = BitW'(WORD_W - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] LastGap = GapW'(SYNC_GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              sync_n_q, sync_n_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            bit_q    <= '0;
            div_q    <= '0;
            gap_q    <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            shreg_q  <= shreg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            sync_n_q <= sync_n_d;
        end
    end

    // Outputs are computed for the next state so every pin comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        div_d    = div_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        sync_n_d = sync_n_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    busy_d  = 1'b1;
                end
            end
            StLoad: begin
                state_d  = StShift;
                shreg_d  = data_in;
                mosi_d   = data_in[WORD_W-1];
                sclk_d   = 1'b1;
                sync_n_d = 1'b0;
                div_d    = '0;
                bit_d    = '0;
            end
            StShift: begin
                if (div_q == LastDiv) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == LastBit) begin
                        state_d  = StGap;
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        mosi_d   = 1'b0;
                        gap_d    = '0;
                    end else begin
                        // Bit boundary: mosi only moves together with the sclk rising edge.
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_d[WORD_W-1];
                        sclk_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == LastGap) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign sync_n = sync_n_q;

endmodule

// File: tb/tb_mems_spi_tx.sv
// Bench for mems_spi_tx: cycle-exact trace model per frame plus a word scoreboard fed by
// an sclk-falling-edge decoder, on a default instance and a CLK_DIV=1/SYNC_GAP=1 instance.
module tb_mems_spi_tx;

    logic        clk;
    logic        rst;
    logic        start, start1;
    logic [23:0] data_in;
    logic        busy, done, sclk, mosi, sync_n;
    logic        busy1, done1, sclk1, mosi1, sync_n1;

    int n_checks = 0;
    int n_errors = 0;
    bit pending  = 0;

    logic [24:0] exp_q[$];

    mems_spi_tx #(.WORD_W(24), .CLK_DIV(2), .SYNC_GAP(2)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data_in(data_in),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .mosi   (mosi),
        .sync_n (sync_n)
    );

    mems_spi_tx #(.WORD_W(24), .CLK_DIV(1), .SYNC_GAP(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .data_in(data_in),
        .busy   (busy1),
        .done   (done1),
        .sclk   (sclk1),
        .mosi   (mosi1),
        .sync_n (sync_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy, done, sync_n, sclk, mosi}
    function automatic logic [4:0] obs(input int inst);
        if (inst == 0) return {busy, done, sync_n, sclk, mosi};
        return {busy1, done1, sync_n1, sclk1, mosi1};
    endfunction

    // Expected pins i cycles after the start cycle.
    function automatic logic [4:0] model(input int cd, input int sg, input logic [23:0] w,
                                         input int i);
        int   s;
        logic b, d, sh, sc, mo;
        s  = 24 * 2 * cd;
        b  = (i >= 1) && (i <= 1 + s + sg);
        d  = (i == 2 + s + sg);
        sh = (i >= 2) && (i <= 1 + s);
        sc = sh ? (((i - 2) % (2 * cd)) < cd) : 1'b1;
        mo = sh ? w[23 - (i - 2) / (2 * cd)] : 1'b0;
        return {b, d, !sh, sc, mo};
    endfunction

    task automatic drive_start(input int inst, input logic v);
        start  = (inst == 0) ? v : 1'b0;
        start1 = (inst == 1) ? v : 1'b0;
    endtask

    task automatic frame(input int inst, input logic [23:0] w, input bit chain,
                         input bit extras, input int abort_at);
        int cd, sg, t;
        cd = (inst == 0) ? 2 : 1;
        sg = (inst == 0) ? 2 : 1;
        t  = 2 + 24 * 2 * cd + sg;
        if (!pending) begin
            @(posedge clk);
            #1;
            drive_start(inst, 1'b1);
            data_in = 24'($urandom);
            @(negedge clk);
            check("idle_at_start", 32'(obs(inst)), 32'h06);
        end
        pending = 1'b0;
        for (int i = 1; i <= t; i++) begin
            @(posedge clk);
            #1;
            drive_start(inst, (chain && i == t) ||
                              (extras && (i == 1 || i == 50 || i == 98)));
            data_in = (i == 1) ? w : 24'($urandom);
            rst     = !(abort_at != 0 && i == abort_at);
            if (i == 1 && abort_at == 0) exp_q.push_back({inst[0], w});
            @(negedge clk);
            if (abort_at != 0 && i == abort_at + 1) begin
                check("abort_state", 32'(obs(inst)), 32'h06);
                return;
            end
            check("trace", 32'(obs(inst)), 32'(model(cd, sg, w, i)));
        end
        pending = chain;
    endtask

    // Decoder: collects mosi on each sclk fall, scores the word when sync_n rises.
    logic [23:0] acc[2];
    int          nb[2];
    logic        ps_sclk[2], ps_sync[2], ps_mosi[2];

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic        c_sclk, c_sync, c_mosi;
            logic [24:0] e;
            c_sclk = (j == 0) ? sclk : sclk1;
            c_sync = (j == 0) ? sync_n : sync_n1;
            c_mosi = (j == 0) ? mosi : mosi1;
            if (!rst) begin
                acc[j]     <= '0;
                nb[j]      <= 0;
                ps_sclk[j] <= 1'b1;
                ps_sync[j] <= 1'b1;
                ps_mosi[j] <= 1'b0;
            end else begin
                if (ps_sclk[j] && !c_sclk) begin
                    check("fall_in_frame", 32'(c_sync), 32'h0);
                    acc[j] <= {acc[j][22:0], c_mosi};
                    nb[j]  <= nb[j] + 1;
                end
                if (c_mosi != ps_mosi[j] && !c_sync && !ps_sync[j])
                    check("mosi_on_rise", 32'(!ps_sclk[j] && c_sclk), 32'h1);
                if (!ps_sync[j] && c_sync) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 32'({j[0], acc[j]}), 32'(e));
                        check("nbits", 32'(nb[j]), 32'd24);
                    end
                    acc[j] <= '0;
                    nb[j]  <= 0;
                end
                ps_sclk[j] <= c_sclk;
                ps_sync[j] <= c_sync;
                ps_mosi[j] <= c_mosi;
            end
        end
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        check("reset0", 32'(obs(0)), 32'h06);
        check("reset1", 32'(obs(1)), 32'h06);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("start_in_reset0", 32'(obs(0)), 32'h06);
            check("start_in_reset1", 32'(obs(1)), 32'h06);
        end

        frame(0, 24'h280001, 1'b0, 1'b0, 0);
        frame(0, 24'hAAAAAA, 1'b1, 1'b0, 0);
        frame(0, 24'h555555, 1'b0, 1'b0, 0);
        frame(0, 24'h3C5A96, 1'b0, 1'b1, 0);
        repeat (5) begin
            @(negedge clk);
            check("no_requeue", 32'(busy), 32'h0);
        end
        frame(0, 24'hFFFFFF, 1'b0, 1'b0, 44);
        frame(0, 24'h123456, 1'b0, 1'b0, 0);
        frame(1, 24'h000001, 1'b0, 1'b0, 0);
        frame(1, 24'($urandom), 1'b1, 1'b0, 0);
        frame(1, 24'($urandom), 1'b0, 1'b0, 0);
        repeat (3) frame(0, 24'($urandom), 1'b0, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("sb_left", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
